// File: rtl/present_iter_ctrl.sv
// Iterative PRESENT-80 encryption controller: one round per clock through a shared round/key datapath.
// Latency: out_valid rises 31 cycles after the accept edge; minimum 33 cycles per block with out_ready high.
// Backpressure: in_ready low while a job is in flight; DONE holds out_valid/out_block until out_ready.
module present_iter_ctrl #(
  parameter int NUM_ROUNDS = 31,
  parameter int BLK_W      = 64,
  parameter int KEY_W      = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             busy,
  output logic [4:0]       round_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             fsm_q;
  fsm_t             fsm_nxt;
  logic [BLK_W-1:0] state_r;
  logic [KEY_W-1:0] key_r;
  logic [4:0]       rnd;

  logic [BLK_W-1:0] rk_mix;
  logic [BLK_W-1:0] sb_out;
  logic [BLK_W-1:0] round_out;
  logic [KEY_W-1:0] key_nxt;
  logic             last_round;
  logic             accept;

  // PRESENT 4-bit S-box, shared by the state nibbles and the key schedule
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  assign last_round = (rnd == 5'(NUM_ROUNDS));
  assign accept     = in_valid && in_ready;

  // Shared round datapath: add-round-key, S-box layer, pLayer, and the next round key
  always_comb begin
    rk_mix    = state_r ^ key_r[79:16];
    sb_out    = '0;
    round_out = '0;
    for (int n = 0; n < 16; n++) begin
      sb_out[4*n +: 4] = sbox(rk_mix[4*n +: 4]);
    end
    // bit j moves to 16*j mod 63; bit 63 is a fixed point
    for (int j = 0; j < 63; j++) begin
      round_out[(16*j) % 63] = sb_out[j];
    end
    round_out[63] = sb_out[63];

    key_nxt          = {key_r[18:0], key_r[79:19]};
    key_nxt[79:76]   = sbox(key_nxt[79:76]);
    key_nxt[19:15]   = key_nxt[19:15] ^ rnd;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_nxt;
    end
  end

  // FSM next-state: accept in IDLE, run until the last round, wait for the consumer in DONE
  always_comb begin
    fsm_nxt = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid)   fsm_nxt = RUN;
      RUN:     if (last_round) fsm_nxt = DONE;
      DONE:    if (out_ready)  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs: pure decodes of registered state, no input-to-output paths
  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q != IDLE);
    round_o   = rnd;
  end

  // Cipher state, round key, round counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= '0;
      key_r     <= '0;
      rnd       <= '0;
      out_block <= '0;
    end else begin
      if (accept) begin
        state_r <= in_block;
        key_r   <= in_key;
        rnd     <= 5'd1;
      end else if (fsm_q == RUN) begin
        if (last_round) begin
          // final whitening uses the key produced in this same cycle
          out_block <= round_out ^ key_nxt[79:16];
          rnd       <= '0;
        end else begin
          state_r <= round_out;
          key_r   <= key_nxt;
          rnd     <= rnd + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_present_iter_ctrl.sv
// Self-checking bench for present_iter_ctrl: known-answer table, random jobs against a reference cipher,
// backpressure hold, back-to-back throughput and reset abort.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_present_iter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_block;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;
  logic        busy;
  logic [4:0]  round_o;

  int n_cmp  = 0;
  int n_fail = 0;

  present_iter_ctrl #(
    .NUM_ROUNDS(31),
    .BLK_W(64),
    .KEY_W(80)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_block(in_block),
    .in_key(in_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block),
    .busy(busy),
    .round_o(round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter plus accept/result monitors, sampled with pre-edge values
  int          cyc = 0;
  int          acc_q[$];
  logic [63:0] res_q[$];
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) res_q.push_back(out_block);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  localparam logic [63:0] SBOX_TAB = 64'h2174_8FE3_DA09_B65C;

  // Reference PRESENT-80 encryption written straight from the cipher definition
  function automatic logic [63:0] present_ref(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] tab;
    logic [63:0] st;
    logic [63:0] sub;
    logic [79:0] k;
    int          dst;
    tab = SBOX_TAB;
    st  = pt;
    k   = key;
    for (int r = 1; r <= 31; r++) begin
      st = st ^ k[79:16];
      for (int n = 0; n < 16; n++) sub[4*n +: 4] = tab[4*st[4*n +: 4] +: 4];
      for (int b = 0; b < 64; b++) begin
        dst = (b == 63) ? 63 : (b * 16) % 63;
        st[dst] = sub[b];
      end
      k = {k[18:0], k[79:19]};
      k[79:76] = tab[4*k[79:76] +: 4];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return st ^ k[79:16];
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // One complete job: offer, track RUN cycles, optionally stall the result, then hand it off
  task automatic do_job(input logic [79:0] k, input logic [63:0] p, input logic [63:0] exp,
                        input int hold, input string tag);
    int          n;
    logic        bad_rnd;
    logic        bad_hold;
    logic [63:0] held;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_key   = k;
    in_block = p;
    @(negedge clk);
    // inputs scrambled right after acceptance must not affect the result
    in_valid = 1'b0;
    in_key   = 80'({$urandom, $urandom, $urandom});
    in_block = {$urandom, $urandom};
    n       = 0;
    bad_rnd = 1'b0;
    while (!out_valid && n < 100) begin
      if (round_o != 5'(n + 1) || !busy || in_ready) bad_rnd = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd31);
    check({tag, " round_seq"}, 64'(bad_rnd), 64'd0);
    check({tag, " ciphertext"}, out_block, exp);
    check({tag, " done_round"}, 64'(round_o), 64'd0);
    held     = out_block;
    bad_hold = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_block !== held || in_ready || !busy) bad_hold = 1'b1;
    end
    if (hold > 0) check({tag, " hold_stable"}, 64'(bad_hold), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, " idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, " result_kept"}, out_block, held);
  endtask

  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
    int          hold;
    string       name;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [79:0] ka, kb, kr;
    logic [63:0] pa, pb, pr;
    int          n;
    int          ov_cnt;

    vecs[0] = '{80'h0, 64'h0, 64'h5579C1387B228445, 0, "kat_k0_p0"};
    vecs[1] = '{{80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 0, "kat_kF_p0"};
    vecs[2] = '{80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, 0, "kat_k0_pF"};
    vecs[3] = '{{80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 10, "kat_kF_pF_stall"};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    in_key    = '0;
    out_ready = 1'b0;
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset round_o", 64'(round_o), 64'd0);
    check("reset out_block", out_block, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_job(vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].hold, vecs[i].name);
    end

    for (int i = 0; i < 8; i++) begin
      kr = 80'({$urandom, $urandom, $urandom});
      pr = {$urandom, $urandom};
      do_job(kr, pr, present_ref(kr, pr), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    // Back-to-back with in_valid held high and inputs changed mid-RUN
    ka = 80'h0123_4567_89AB_CDEF_1357;
    pa = 64'hDEAD_BEEF_0BAD_F00D;
    kb = 80'hFEDC_BA98_7654_3210_ACE0;
    pb = 64'h1122_3344_5566_7788;
    acc_q.delete();
    res_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_key    = ka;
    in_block  = pa;
    n = 0;
    while (acc_q.size() < 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    in_key   = kb;
    in_block = pb;
    n = 0;
    while (acc_q.size() < 2 && n < 80) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    in_key   = 80'({$urandom, $urandom, $urandom});
    in_block = {$urandom, $urandom};
    n = 0;
    while (res_q.size() < 2 && n < 80) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check("b2b accepts", 64'(acc_q.size()), 64'd2);
    check("b2b results", 64'(res_q.size()), 64'd2);
    if (acc_q.size() >= 2) check("b2b accept_gap", 64'(acc_q[1] - acc_q[0]), 64'd33);
    if (res_q.size() >= 2) begin
      check("b2b result0", res_q[0], present_ref(ka, pa));
      check("b2b result1", res_q[1], present_ref(kb, pb));
    end

    // Reset during round 15 aborts the job without any output
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = '0;
    in_block = '0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round_o != 5'd15 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort round_o_before", 64'(round_o), 64'd15);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort round_o", 64'(round_o), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_block", out_block, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    ov_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) ov_cnt++;
    end
    check("abort no_spurious", 64'(ov_cnt), 64'd0);
    do_job(80'h0, 64'h0, 64'h5579C1387B228445, 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
